// File: rtl/minute_tick_gen.sv
// Timebase for the time-of-day counter: divides clk into single-cycle
// one_second and one_minute strobes, with a fast_watch mode for lab checks.
module minute_tick_gen #(
  parameter int unsigned CLKS_PER_SEC = 256,
  parameter int unsigned SECS_PER_MIN = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic reset_count,
  input  logic fast_watch,
  output logic one_second,
  output logic one_minute
);

  localparam int unsigned SW = $clog2(CLKS_PER_SEC);
  localparam int unsigned MW = $clog2(SECS_PER_MIN);
  localparam logic [SW-1:0] SEC_LAST = SW'(CLKS_PER_SEC - 1);
  localparam logic [MW-1:0] MIN_LAST = MW'(SECS_PER_MIN - 1);

  logic [SW-1:0] sec_div_q, sec_div_d;
  logic [MW-1:0] min_div_q, min_div_d;
  logic          one_second_q, one_second_d;
  logic          one_minute_q, one_minute_d;
  logic          sec_wrap, min_wrap;

  always_comb begin
    sec_wrap     = (sec_div_q == SEC_LAST);
    min_wrap     = sec_wrap && (min_div_q == MIN_LAST);
    sec_div_d    = sec_wrap ? '0 : sec_div_q + SW'(1);
    min_div_d    = min_div_q;
    one_second_d = sec_wrap;
    // fast_watch only matters on a wrap edge; min_div keeps its phase either way
    one_minute_d = fast_watch ? sec_wrap : min_wrap;
    if (sec_wrap) begin
      min_div_d = min_wrap ? '0 : min_div_q + MW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || reset_count) begin
      sec_div_q    <= '0;
      min_div_q    <= '0;
      one_second_q <= 1'b0;
      one_minute_q <= 1'b0;
    end else begin
      sec_div_q    <= sec_div_d;
      min_div_q    <= min_div_d;
      one_second_q <= one_second_d;
      one_minute_q <= one_minute_d;
    end
  end

  assign one_second = one_second_q;
  assign one_minute = one_minute_q;

endmodule

// File: tb/tb_minute_tick_gen.sv
// Directed bench for minute_tick_gen (CLKS_PER_SEC=4, SECS_PER_MIN=3) with a
// scoreboard queue of expected strobe values drained by a negedge monitor.
module tb_minute_tick_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset_count = 1'b0;
  logic fast_watch = 1'b0;
  logic one_second;
  logic one_minute;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    int unsigned case_id;
    int unsigned edge_n;
    logic        sec;
    logic        min;
  } exp_t;

  exp_t exp_q[$];

  minute_tick_gen #(
    .CLKS_PER_SEC(4),
    .SECS_PER_MIN(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .reset_count(reset_count),
    .fast_watch (fast_watch),
    .one_second (one_second),
    .one_minute (one_minute)
  );

  always #5 clk = ~clk;

  // Monitor: one expected entry per edge, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (one_second !== e.sec || one_minute !== e.min) begin
          errors++;
          $display("FAIL case%0d edge%0d strobes: got sec=%b min=%b, expected sec=%b min=%b",
                   e.case_id, e.edge_n, one_second, one_minute, e.sec, e.min);
        end
      end
    end
  end

  task automatic push_exp(input int unsigned cid, input int unsigned n,
                          input logic s, input logic m);
    exp_t e;
    e.case_id = cid;
    e.edge_n  = n;
    e.sec     = s;
    e.min     = m;
    exp_q.push_back(e);
  endtask

  // Bit k of each mask applies to edge k after reset release (k = 1..30).
  task automatic run_case(input int unsigned cid,
                          input logic [31:0] rst_m, input logic [31:0] rc_m,
                          input logic [31:0] fw_m,
                          input logic [31:0] sec_m, input logic [31:0] min_m);
    reset       = 1'b1;
    reset_count = 1'b0;
    fast_watch  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      push_exp(cid, 0, 1'b0, 1'b0);
    end
    for (int k = 1; k <= 30; k++) begin
      reset       = rst_m[k];
      reset_count = rc_m[k];
      fast_watch  = fw_m[k];
      @(posedge clk);
      #1;
      push_exp(cid, k, sec_m[k], min_m[k]);
    end
  endtask

  initial begin
    // 1: normal mode from reset
    run_case(1, 32'h0, 32'h0, 32'h0, 32'h1111_1110, 32'h0100_1000);
    // 2: fast_watch throughout, one_minute tracks one_second
    run_case(2, 32'h0, 32'h0, 32'h7FFF_FFFE, 32'h1111_1110, 32'h1111_1110);
    // 3: fast_watch on for edges 6..12, minute phase kept on return
    run_case(3, 32'h0, 32'h0, 32'h0000_1FC0, 32'h1111_1110, 32'h0100_1100);
    // 4: reset_count pulse at edge 6 restarts both dividers
    run_case(4, 32'h0, 32'h0000_0040, 32'h0, 32'h4444_4410, 32'h4004_0000);
    // 5: reset at edge 12 suppresses the pending minute strobe
    run_case(5, 32'h0000_1000, 32'h0, 32'h0, 32'h1111_0110, 32'h0100_0000);
    // 6: reset and reset_count together for edges 1..3
    run_case(6, 32'h0000_000E, 32'h0000_000E, 32'h0, 32'h0888_8880, 32'h0800_8000);

    reset = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/minute_tick_gen.md
Name: minute_tick_gen

Overview:
Timebase generator directly upstream of the time-of-day counter. Divides the system clock into single-cycle one_second and one_minute strobes. The counter consumes one_minute as its increment enable. A fast_watch mode speeds up minute advance so the clock can be checked in the lab. reset_count lets the time-load path restart the minute boundary whenever a new time is loaded.

Parameters:
CLKS_PER_SEC, 256, clk cycles per second; legal range >= 2.
SECS_PER_MIN, 60, seconds per minute; legal range >= 2.

Ports:
clk  input  1  system clock; all logic is on its rising edge.
reset  input  1  synchronous, active-high; clears all state.
reset_count  input  1  synchronous clear of the divider chain; driven together with load_new_c.
fast_watch  input  1  1 = one_minute strobes every second.
one_second  output  1  single-cycle strobe, once per CLKS_PER_SEC cycles.
one_minute  output  1  single-cycle strobe to the counter's one_minute input.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high. No asynchronous paths.
- Internal state:
  - sec_div: width $clog2(CLKS_PER_SEC), range 0..CLKS_PER_SEC-1.
  - min_div: width $clog2(SECS_PER_MIN), range 0..SECS_PER_MIN-1.
- Both outputs are registered. No combinational path from any input to any output.
- Reset values: sec_div=0, min_div=0, one_second=0, one_minute=0.
- Priority at each clk edge: reset > reset_count > normal count.
- reset_count=1 has the same effect as reset on all state and outputs.
- Normal count:
  - sec_wrap = (sec_div == CLKS_PER_SEC-1).
  - sec_div <= sec_wrap ? 0 : sec_div+1.
  - one_second <= sec_wrap.
  - min_wrap = sec_wrap & (min_div == SECS_PER_MIN-1).
  - On sec_wrap, min_div <= min_wrap ? 0 : min_div+1. Otherwise min_div holds.
  - one_minute <= fast_watch ? sec_wrap : min_wrap.
- Latency:
  - First one_second is high in the cycle after the CLKS_PER_SEC-th edge following reset/reset_count release.
  - First one_minute (normal mode) comes after CLKS_PER_SEC*SECS_PER_MIN edges and coincides with a one_second strobe.
- Strobes are never high for two consecutive cycles.
- In normal mode, one_minute is never high without one_second.
- fast_watch:
  - Sampled only on a sec_wrap edge. Toggling it between wraps has no effect until the next wrap.
  - min_div keeps counting in fast mode, so returning to normal mode resumes the existing minute phase. It does not restart.
- reset or reset_count asserted while a strobe is high: the strobe drops at that edge and the divider restarts from 0.
- Holding reset_count for N cycles holds everything at 0. Counting resumes on the first edge with reset_count=0.
- Counter wrap: no out-of-range divider values are reachable. Width arithmetic is modulo-free because values are compared before increment.

Test Plan:
All cases use CLKS_PER_SEC=4, SECS_PER_MIN=3. Cycle n = n-th edge after reset deasserts.
1. Release reset, fast_watch=0 -> one_second high after edges 4, 8, 12, 16...; one_minute high only after edge 12 and edge 24, each for 1 cycle, coincident with one_second.
2. fast_watch=1 from reset -> one_minute high after edges 4, 8, 12 (identical to one_second).
3. fast_watch switches 0->1 at edge 6 -> one_minute first high after edge 8. Switch back to 0 at edge 13 -> next one_minute after edge 24 (min_div phase preserved).
4. Pulse reset_count at edge 6 -> no strobe after edge 8. one_second next high after edge 10 (6+4); one_minute after edge 18.
5. Assert reset at edge 12 while one_minute is about to rise -> both outputs stay 0. One_minute returns 12 edges after reset deasserts.
6. reset and reset_count both high for 3 cycles -> all outputs 0 throughout. Timing after release matches case 1.
